bit_stream_tx: RTL

BIT_STREAM_TX -- requirements
Module: bit_stream_tx

---
 rtl/bit_stream_tx.sv | 99 +++++++++
 1 files changed

// File: rtl/bit_stream_tx.sv
// Serializer that frames each accepted payload word as: sync pattern, payload
// (both MSB first), then one even-parity bit, with back-to-back frames allowed.
module bit_stream_tx #(
  parameter int                  SYNC_LEN  = 7,
  parameter logic [SYNC_LEN-1:0] SYNC_WORD = 7'b1001001,
  parameter int                  DATA_W    = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DATA_W-1:0] data_in,
  input  logic              data_valid,
  output logic              data_ready,
  output logic              dout,
  output logic              frame_start,
  output logic [1:0]        state
);

  localparam int MAX_LEN = (SYNC_LEN > DATA_W) ? SYNC_LEN : DATA_W;
  localparam int CNT_W   = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
  localparam int SH_W    = SYNC_LEN - 1 + DATA_W;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SYNC   = 2'd1,
    DATA   = 2'd2,
    PARITY = 2'd3
  } state_t;

  state_t            st;
  logic [SH_W-1:0]   sh;
  logic [CNT_W-1:0]  cnt;
  logic              par;
  logic              accept;

  function automatic logic even_parity(input logic [DATA_W-1:0] d);
    return ^d;
  endfunction

  // Ready is gated by rst_n so it drops immediately while reset is held.
  assign data_ready = rst_n && ((st == IDLE) || (st == PARITY));
  assign accept     = data_valid && data_ready;
  assign state      = st;

  // The first sync bit goes straight to dout at accept; the rest of the sync
  // pattern and the payload share one shift register, MSB leaving first.
  // cnt holds the number of bits of the current phase still to follow.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st          <= IDLE;
      dout        <= 1'b0;
      frame_start <= 1'b0;
      sh          <= '0;
      cnt         <= '0;
      par         <= 1'b0;
    end else begin
      frame_start <= 1'b0;
      case (st)
        IDLE, PARITY: begin
          if (accept) begin
            st          <= SYNC;
            dout        <= SYNC_WORD[SYNC_LEN-1];
            frame_start <= 1'b1;
            sh          <= {SYNC_WORD[SYNC_LEN-2:0], data_in};
            cnt         <= CNT_W'(SYNC_LEN - 1);
            par         <= even_parity(data_in);
          end else begin
            st   <= IDLE;
            dout <= 1'b0;
          end
        end
        SYNC: begin
          dout <= sh[SH_W-1];
          sh   <= {sh[SH_W-2:0], 1'b0};
          if (cnt == '0) begin
            st  <= DATA;
            cnt <= CNT_W'(DATA_W - 1);
          end else begin
            cnt <= cnt - CNT_W'(1);
          end
        end
        DATA: begin
          if (cnt == '0) begin
            st   <= PARITY;
            dout <= par;
          end else begin
            dout <= sh[SH_W-1];
            sh   <= {sh[SH_W-2:0], 1'b0};
            cnt  <= cnt - CNT_W'(1);
          end
        end
        default: begin
          st   <= IDLE;
          dout <= 1'b0;
        end
      endcase
    end
  end

endmodule
